fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; legal values 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1 and imem_gnt=0.
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  response data valid; responses return in request order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  control-flow change from execute (branch/jump taken).
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 out_valid  output  1  instruction available to decoder.
REQ-013 out_ready  input  1  decoder accepts instruction.
REQ-014 out_instruction  output  32  instruction word to decoder.
REQ-015 out_pc  output  32  address of out_instruction.
REQ-016 fetch_fault  output  1  misaligned redirect target (present only with FETCH_MISALIGN_CHECK_EN).

Function
REQ-017 fetch_pc SHALL advance by 4 on every granted request; outputs SHALL be driven from a BUF_DEPTH-entry FIFO of {pc, instruction}.
REQ-018 imem_req SHALL be 1 only when outstanding + buffered entries < BUF_DEPTH, guaranteeing no FIFO overflow.
REQ-019 Outstanding count SHALL increment on grant, decrement on rvalid; a simultaneous grant and rvalid SHALL leave it unchanged.
REQ-020 Each non-discarded rvalid SHALL push {pc of matching request, imem_rdata}; pc taken from an in-order outstanding-pc queue.
REQ-021 Transfer occurs when out_valid and out_ready; FIFO pops that cycle; simultaneous push and pop to a full FIFO SHALL be legal.
REQ-022 Empty FIFO with an arriving response SHALL NOT bypass; out_valid asserts the following cycle (minimum latency grant-to-out_valid = 2 cycles).
REQ-023 out_instruction and out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 redirect_valid SHALL, in the same edge: flush FIFO, set fetch_pc=redirect_pc, and mark all outstanding responses as discard (kill counter = outstanding, minus any rvalid that cycle).
REQ-025 out_valid SHALL be 0 in the cycle after a redirect; a transfer coincident with redirect_valid is still counted as consumed.
REQ-026 Discarded rvalid beats SHALL decrement the kill counter and never enter the FIFO.
REQ-027 A request issued in the redirect cycle SHALL use the old fetch_pc and be killed; first post-redirect request addresses redirect_pc.
REQ-028 State machine: RESET -> RUN on first cycle after rst deasserts; RUN -> FAULT per REQ-034; FAULT -> RUN on aligned redirect.
REQ-029 fetch_pc and all PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-030 rst SHALL asynchronously clear: FIFO, outstanding and kill counters, imem_req=0, out_valid=0, out_instruction=0, out_pc=0, fetch_fault=0, state=RESET.
REQ-031 fetch_pc SHALL reset to RESET_PC; first imem_req SHALL assert the first cycle after rst deasserts.
REQ-032 Responses arriving after reset for pre-reset requests are outside protocol; memory SHALL be reset with the unit.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHECK_EN compiles the alignment check and fetch_fault port in.
REQ-034 With it: redirect_pc[1:0]!=0 SHALL flush as REQ-024, enter FAULT, hold imem_req=0, assert fetch_fault until the next aligned redirect.
REQ-035 Without it: port absent, redirect_pc[1:0] SHALL be forced to 0, FAULT state absent.

Structure
REQ-036 Shared package SHALL hold fetch state enum, the {pc, instruction} FIFO entry struct, and RESET_PC default constant.
REQ-037 FIFO SHALL be sub-module fetch_buffer (parameterised depth, push/pop/flush, full/empty).

Verification
REQ-038 Reset release, memory grants every cycle, rvalid 1 cycle later -> imem_addr 0,4,8; out_pc 0,4,8 in order with matching words.
REQ-039 out_ready=0 for 5 cycles -> imem_req drops once FIFO+outstanding=2; out_instruction stable; no data lost on release.
REQ-040 redirect_pc=32'h100 with 2 outstanding -> both responses discarded; next out_pc=32'h100.
REQ-041 Redirect coincident with rvalid and out transfer -> counters consistent, no stale entry emitted.
REQ-042 fetch_pc near 32'hFFFF_FFF8 -> addresses ...F8, ...FC, 0.
REQ-043 With macro, redirect_pc=32'h102 -> fetch_fault=1, imem_req=0; redirect 32'h200 clears fault and resumes fetch.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_MISALIGN_CHECK_EN adds the FAULT state used by the redirect alignment check.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Wide enough for outstanding, kill and buffer counts up to a depth of 4.
  localparam int unsigned CNT_W = 3;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FAULT} fetch_state_e;
`else
  typedef enum logic [1:0] {ST_RESET, ST_RUN} fetch_state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instruction} entries feeding the decoder.
// Flush has priority; a push and a pop in the same cycle are legal even when full.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       pop_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; pop_data is masked while empty so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch unit with redirect flush and response kill tracking.
// Define FETCH_MISALIGN_CHECK_EN to add the misaligned-redirect check and the fetch_fault port.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d, kill_q, kill_d;
  logic [31:0]      pcq_mem [BUF_DEPTH];
  logic [PW-1:0]    pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]      redir_tgt;
  logic             gnt_fire, rsp_live, buf_push;
  logic             buf_full, buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     push_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned  = |redirect_pc[1:0];
  assign redir_tgt   = redirect_pc;
  assign fetch_fault = (state_q == ST_FAULT);
`else
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    // Killed responses still occupy outstanding slots, so the room check stays conservative.
    imem_req = (state_q == ST_RUN) && !buf_full &&
               ((4'(outst_q) + 4'(buf_count)) < 4'(BUF_DEPTH));
    gnt_fire = imem_req && imem_gnt;
    rsp_live = imem_rvalid && (kill_q == '0);
    buf_push = rsp_live && !redirect_valid;
    push_entry = '{pc: pcq_mem[pcq_rd_q], instr: imem_rdata};

    outst_d = outst_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);

    kill_d = kill_q;
    if (redirect_valid) kill_d = outst_d;
    else if (imem_rvalid && kill_q != '0) kill_d = kill_q - CNT_W'(1);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redir_tgt;
    else if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    pcq_wr_d = pcq_wr_q;
    pcq_rd_d = pcq_rd_q;
    if (redirect_valid) begin
      pcq_wr_d = '0;
      pcq_rd_d = '0;
    end else begin
      if (gnt_fire) pcq_wr_d = pcq_wr_q + PW'(1);
      if (rsp_live) pcq_rd_d = pcq_rd_q + PW'(1);
    end

    state_d = ST_RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redirect_valid) state_d = misaligned ? ST_FAULT : ST_RUN;
    else if (state_q == ST_FAULT) state_d = ST_FAULT;
`endif
  end

  always_ff @(posedge clk) begin
    if (gnt_fire && !redirect_valid) pcq_mem[pcq_wr_q] <= fetch_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .flush     (redirect_valid),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign imem_addr       = fetch_pc_q;
  assign out_valid       = !buf_empty;
  assign out_pc          = head.pc;
  assign out_instruction = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model and an expected-output queue.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_rsp_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] gaddr_q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_en, rdy, redir, prev_redir, hold_v, xfer_seen;
  logic [31:0] redir_pc, exp_pc, hold_pc, hold_instr, last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] redir_target(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs just after negedge, score outputs, advance to next negedge.
  task automatic tick();
    bit   rv;
    exp_t e;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(mem_q[0].addr) : 32'h0;
    imem_gnt       = gnt_en;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    #1;
    if (prev_redir) check("valid_after_redirect", 32'(out_valid), 32'd0);
    if (hold_v) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, hold_pc);
      check("hold_instr", out_instruction, hold_instr);
    end
    if (out_valid && out_ready) begin
      check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instruction, e.instr);
      end
      last_pc   = out_pc;
      xfer_seen = 1'b1;
    end
    if (rv) void'(mem_q.pop_front());
    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, exp_pc);
      mem_q.push_back('{imem_addr, cyc + lat});
      gaddr_q.push_back(imem_addr);
      if (!redir) exp_q.push_back('{exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = redir_target(redir_pc);
    end
    hold_v     = out_valid && !out_ready && !redir;
    hold_pc    = out_pc;
    hold_instr = out_instruction;
    prev_redir = redir;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redir    = 1'b1;
    redir_pc = pc;
    tick();
    redir     = 1'b0;
    xfer_seen = 1'b0;
    gaddr_q.delete();
  endtask

  task automatic wait_xfer(input string tag);
    int n = 0;
    while (!xfer_seen && n < 30) begin tick(); n++; end
    check(tag, 32'(xfer_seen), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int cnt);
    int n = 0;
    while (gaddr_q.size() < cnt && n < 30) begin tick(); n++; end
    check(tag, 32'(gaddr_q.size() >= cnt), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    gnt_en = 1'b0;
    while ((mem_q.size() != 0 || exp_q.size() != 0) && n < 40) begin tick(); n++; end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    gnt_en = 1'b0; rdy = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    prev_redir = 1'b0; hold_v = 1'b0; xfer_seen = 1'b0;
    exp_pc = 32'h0; last_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state.
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instruction, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_fault", 32'(fetch_fault), 32'd0);
`endif

    // Release reset: first request at RESET_PC, no bypass, two-cycle latency.
    rst = 1'b0;
    gnt_en = 1'b1;
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("no_bypass", 32'(out_valid), 32'd0);
    tick();
    check("lat2_valid", 32'(out_valid), 32'd1);
    check("lat2_pc", out_pc, 32'h0);
    repeat (6) tick();
    check("addr0", gaddr_q[0], 32'h0);
    check("addr1", gaddr_q[1], 32'h4);
    check("addr2", gaddr_q[2], 32'h8);

    // Decoder stall: request stops at capacity, held output stable, nothing lost.
    rdy = 1'b0;
    repeat (5) tick();
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_inflight", 32'(exp_q.size()), 32'(DEPTH));
    rdy = 1'b1;
    repeat (8) tick();

    // Redirect with two requests outstanding.
    lat = 3;
    n = 0;
    while (mem_q.size() < 2 && n < 20) begin tick(); n++; end
    check("two_outstanding", 32'(mem_q.size()), 32'd2);
    do_redirect(32'h100);
    wait_xfer("redir100_xfer");
    check("redir100_pc", last_pc, 32'h100);
    check("redir100_addr", gaddr_q[0], 32'h100);
    lat = 1;
    repeat (6) tick();

    // Redirect coincident with a response and a transfer.
    n = 0;
    while (!(out_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin tick(); n++; end
    check("coincident_found", 32'(n < 20), 32'd1);
    do_redirect(32'h200);
    wait_xfer("redir200_xfer");
    check("redir200_pc", last_pc, 32'h200);
    drain("drain_after_coincident");
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_req", 32'(imem_req), 32'd1);
    gnt_en = 1'b1;

    // Fetch address wraps modulo 2^32.
    do_redirect(32'hFFFF_FFF8);
    wait_grants("wrap_grants", 3);
    check("wrap_f8", gaddr_q[0], 32'hFFFF_FFF8);
    check("wrap_fc", gaddr_q[1], 32'hFFFF_FFFC);
    check("wrap_0", gaddr_q[2], 32'h0000_0000);
    repeat (8) tick();

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect faults and stops fetch until an aligned redirect.
    do_redirect(32'h102);
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_req", 32'(imem_req), 32'd0);
    repeat (3) tick();
    check("fault_hold", 32'(fetch_fault), 32'd1);
    check("fault_hold_req", 32'(imem_req), 32'd0);
    do_redirect(32'h200);
    check("fault_clear", 32'(fetch_fault), 32'd0);
    wait_grants("resume_grant", 1);
    check("resume_addr", gaddr_q[0], 32'h200);
`else
    // Low target bits are ignored without the alignment check.
    do_redirect(32'h102);
    wait_grants("align_grant", 1);
    check("align_addr", gaddr_q[0], 32'h100);
`endif
    repeat (6) tick();

    drain("final_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
